// File: rtl/aes_byte_stream_frontend.sv
// Byte-serial front end for aes_256: shifts in key/plaintext bytes, waits the core latency,
// then streams the 16 ciphertext bytes back out MSB-first.
//
// state    | meaning
// IDLE     | waiting for the first byte of a frame
// LOAD_KEY | shifting in the 32 key bytes
// LOAD_MSG | shifting in the 16 plaintext bytes
// WAIT     | key/msg held on the core inputs until the ciphertext is valid
// SEND     | streaming the captured ciphertext out
module aes_byte_stream_frontend #(
   parameter int AES_LATENCY = 30
) (
   input  logic         CLK,
   input  logic         Reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         reuse_key,
   output logic [127:0] aes_msg,
   output logic [255:0] aes_key,
   input  logic [127:0] aes_ct,
   output logic [7:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         key_loaded
);

   localparam int WW = (AES_LATENCY > 1) ? $clog2(AES_LATENCY) : 1;
   localparam logic [WW-1:0] WAIT_LOAD = WW'(AES_LATENCY - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_KEY,
      ST_LOAD_MSG,
      ST_WAIT,
      ST_SEND
   } state_t;

   state_t         state_q, state_d;
   logic [255:0]   key_q, key_d;
   logic [127:0]   msg_q, msg_d;
   logic [127:0]   ct_q, ct_d;
   logic [4:0]     byte_cnt_q, byte_cnt_d;
   logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [3:0]     out_cnt_q, out_cnt_d;
   logic           key_loaded_q, key_loaded_d;
   logic           out_valid_q, out_valid_d;
   logic           in_fire, out_fire;

   assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD_KEY) || (state_q == ST_LOAD_MSG);
   assign in_fire    = in_valid & in_ready;
   assign out_fire   = out_valid_q & out_ready;
   assign aes_msg    = msg_q;
   assign aes_key    = key_q;
   assign out_data   = ct_q[127:120];
   assign out_valid  = out_valid_q;
   assign busy       = (state_q != ST_IDLE);
   assign key_loaded = key_loaded_q;

   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      msg_d        = msg_q;
      ct_d         = ct_q;
      byte_cnt_d   = byte_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      out_cnt_d    = out_cnt_q;
      key_loaded_d = key_loaded_q;
      case (state_q)
         ST_IDLE: begin
            if (in_fire) begin
               byte_cnt_d = 5'd1;
               // A reuse request without a held key falls back to a full key frame.
               if (reuse_key && key_loaded_q) begin
                  msg_d   = {msg_q[119:0], in_data};
                  state_d = ST_LOAD_MSG;
               end else begin
                  key_d        = {key_q[247:0], in_data};
                  key_loaded_d = 1'b0;
                  state_d      = ST_LOAD_KEY;
               end
            end
         end
         ST_LOAD_KEY: begin
            if (in_fire) begin
               key_d = {key_q[247:0], in_data};
               if (byte_cnt_q == 5'd31) begin
                  key_loaded_d = 1'b1;
                  byte_cnt_d   = 5'd0;
                  state_d      = ST_LOAD_MSG;
               end else begin
                  byte_cnt_d = byte_cnt_q + 5'd1;
               end
            end
         end
         ST_LOAD_MSG: begin
            if (in_fire) begin
               msg_d = {msg_q[119:0], in_data};
               if (byte_cnt_q == 5'd15) begin
                  byte_cnt_d = 5'd0;
                  wait_cnt_d = WAIT_LOAD;
                  state_d    = ST_WAIT;
               end else begin
                  byte_cnt_d = byte_cnt_q + 5'd1;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == '0) begin
               ct_d      = aes_ct;
               out_cnt_d = 4'd0;
               state_d   = ST_SEND;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         ST_SEND: begin
            if (out_fire) begin
               ct_d = {ct_q[119:0], 8'h00};
               if (out_cnt_q == 4'd15) begin
                  out_cnt_d = 4'd0;
                  state_d   = ST_IDLE;
               end else begin
                  out_cnt_d = out_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      out_valid_d = (state_d == ST_SEND);
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q      <= ST_IDLE;
         key_q        <= '0;
         msg_q        <= '0;
         ct_q         <= '0;
         byte_cnt_q   <= '0;
         wait_cnt_q   <= '0;
         out_cnt_q    <= '0;
         key_loaded_q <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         msg_q        <= msg_d;
         ct_q         <= ct_d;
         byte_cnt_q   <= byte_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         out_cnt_q    <= out_cnt_d;
         key_loaded_q <= key_loaded_d;
         out_valid_q  <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_aes_byte_stream_frontend.sv
// Bench for aes_byte_stream_frontend with a pipelined stand-in core that knows the FIPS-197 C.3
// vector and returns an unrelated word for any other key/plaintext pair.
module tb_aes_byte_stream_frontend;

   localparam int LAT = 8;
   localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         CLK;
   logic         Reset;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic         reuse_key;
   logic [127:0] aes_msg;
   logic [255:0] aes_key;
   logic [127:0] aes_ct;
   logic [7:0]   out_data;
   logic         out_valid;
   logic         out_ready;
   logic         busy;
   logic         key_loaded;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   aes_byte_stream_frontend #(.AES_LATENCY(LAT)) dut (
      .CLK(CLK), .Reset(Reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .reuse_key(reuse_key), .aes_msg(aes_msg), .aes_key(aes_key), .aes_ct(aes_ct),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .key_loaded(key_loaded)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [127:0] core_f(input logic [127:0] m, input logic [255:0] k);
      if (k == FIPS_KEY && m == FIPS_PT) return FIPS_CT;
      return m ^ k[255:128] ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   // Result for inputs stable after edge T is visible only from edge T+LAT on.
   logic [127:0] core_pipe [0:LAT-2];
   always @(posedge CLK) begin
      core_pipe[0] <= core_f(aes_msg, aes_key);
      for (int k = 1; k < LAT - 1; k++) core_pipe[k] <= core_pipe[k-1];
   end
   assign aes_ct = core_pipe[LAT-2];

   task automatic send_frame(input int nbytes, input bit with_key, input bit reuse, input bit gaps,
                             input string tag);
      logic [255:0] kv;
      logic [127:0] pv;
      logic [127:0] cv;
      logic [7:0]   b;
      bit           acc;
      int           k;
      int           g;
      int           nkey;
      kv   = FIPS_KEY;
      pv   = FIPS_PT;
      cv   = FIPS_CT;
      nkey = with_key ? 32 : 0;
      if (nbytes == nkey + 16)
         for (int i = 0; i < 16; i++) exp_q.push_back(cv[127-8*i -: 8]);
      reuse_key = reuse;
      for (int i = 0; i < nbytes; i++) begin
         b = (i < nkey) ? kv[255-8*i -: 8] : pv[127-8*(i-nkey) -: 8];
         g = 0;
         if (gaps) while ($urandom_range(0, 1) == 1 && g < 4) begin
            in_valid = 1'b0;
            g++;
            @(posedge CLK); #1;
         end
         in_valid = 1'b1;
         in_data  = b;
         acc = 1'b0;
         k   = 0;
         while (!acc && k < 50) begin
            acc = in_ready;
            @(posedge CLK); #1;
            k++;
         end
         total++;
         if (!acc) begin
            bad++;
            $display("FAIL %s accept byte %0d: in_ready stayed 0, required 1", tag, i);
         end
         if (with_key && i == 0) begin
            total++;
            if (key_loaded !== 1'b0) begin
               bad++;
               $display("FAIL %s key_loaded after key byte 1: got %b want 0", tag, key_loaded);
            end
         end
         if (with_key && i == 31) begin
            total++;
            if (key_loaded !== 1'b1) begin
               bad++;
               $display("FAIL %s key_loaded after key byte 32: got %b want 1", tag, key_loaded);
            end
         end
      end
      in_valid = 1'b0;
      if (nbytes == nkey + 16) begin
         total++;
         if (in_ready !== 1'b0 || busy !== 1'b1 || key_loaded !== 1'b1) begin
            bad++;
            $display("FAIL %s end of input: in_ready=%b busy=%b key_loaded=%b want 0 1 1",
                     tag, in_ready, busy, key_loaded);
         end
      end
   endtask

   task automatic recv_frame(input bit bp, input string tag);
      int         lat;
      int         got;
      int         cyc;
      bit         stall;
      logic [7:0] prev;
      logic [7:0] want;
      lat   = 0;
      got   = 0;
      cyc   = 0;
      stall = 1'b0;
      prev  = 8'h00;
      out_ready = 1'b1;
      while (out_valid !== 1'b1 && lat < LAT + 20) begin
         @(posedge CLK); #1;
         lat++;
      end
      total++;
      if (lat != LAT) begin
         bad++;
         $display("FAIL %s latency: got %0d cycles want %0d", tag, lat, LAT);
      end
      while (got < 16 && cyc < 200) begin
         out_ready = bp ? (cyc % 3 == 0) : 1'b1;
         if (stall) begin
            total++;
            if (out_data !== prev || out_valid !== 1'b1) begin
               bad++;
               $display("FAIL %s hold under stall: data=%h valid=%b want %h 1", tag, out_data, out_valid, prev);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL %s extra byte: got %h want none", tag, out_data);
            end else begin
               want = exp_q.pop_front();
               if (out_data !== want) begin
                  bad++;
                  $display("FAIL %s ct byte %0d: got %h want %h", tag, got, out_data, want);
               end
            end
            got++;
         end
         stall = (out_valid === 1'b1) && !out_ready;
         prev  = out_data;
         @(posedge CLK); #1;
         cyc++;
      end
      out_ready = 1'b1;
      total++;
      if (got != 16 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s transfer count: got %0d left %0d want 16 left 0", tag, got, exp_q.size());
      end
      repeat (3) begin
         total++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after frame: out_valid=%b busy=%b want 0 0", tag, out_valid, busy);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_reset();
      Reset    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (3) @(posedge CLK);
      #1;
      total++;
      if ({aes_msg, aes_key, out_data, out_valid, busy, key_loaded, in_ready} !== {392'h0, 4'b0001}) begin
         bad++;
         $display("FAIL reset values: msg=%h key=%h out=%h ov=%b busy=%b kl=%b rdy=%b want zeros, rdy=1",
                  aes_msg, aes_key, out_data, out_valid, busy, key_loaded, in_ready);
      end
      Reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge CLK); #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset byte ignored: busy=%b want 0", busy);
      end
   endtask

   task automatic test_fips();
      send_frame(48, 1'b1, 1'b0, 1'b0, "fips");
      total++;
      if (aes_key !== FIPS_KEY || aes_msg !== FIPS_PT) begin
         bad++;
         $display("FAIL fips core inputs: key=%h msg=%h want %h %h", aes_key, aes_msg, FIPS_KEY, FIPS_PT);
      end
      recv_frame(1'b0, "fips");
   endtask

   task automatic test_reuse();
      send_frame(16, 1'b0, 1'b1, 1'b0, "reuse");
      recv_frame(1'b0, "reuse");
   endtask

   task automatic test_backpressure();
      send_frame(16, 1'b0, 1'b1, 1'b0, "bp");
      recv_frame(1'b1, "bp");
   endtask

   task automatic test_gaps();
      send_frame(48, 1'b1, 1'b0, 1'b1, "gaps");
      recv_frame(1'b0, "gaps");
   endtask

   task automatic test_reset_mid_frame();
      send_frame(40, 1'b1, 1'b0, 1'b0, "midrst");
      Reset    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      @(posedge CLK); #1;
      total++;
      if ({aes_msg, aes_key, out_data, out_valid, busy, key_loaded, in_ready} !== {392'h0, 4'b0001}) begin
         bad++;
         $display("FAIL midrst values: msg=%h key=%h out=%h ov=%b busy=%b kl=%b rdy=%b want zeros, rdy=1",
                  aes_msg, aes_key, out_data, out_valid, busy, key_loaded, in_ready);
      end
      Reset    = 1'b1;
      in_valid = 1'b0;
      send_frame(48, 1'b1, 1'b0, 1'b0, "midrst");
      recv_frame(1'b0, "midrst");
   endtask

   task automatic test_reuse_without_key();
      Reset = 1'b0;
      @(posedge CLK); #1;
      Reset = 1'b1;
      total++;
      if (key_loaded !== 1'b0) begin
         bad++;
         $display("FAIL nokey key_loaded after reset: got %b want 0", key_loaded);
      end
      send_frame(48, 1'b1, 1'b1, 1'b0, "nokey");
      recv_frame(1'b0, "nokey");
   endtask

   initial begin
      Reset     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      reuse_key = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_fips();
      test_reuse();
      test_backpressure();
      test_gaps();
      test_reset_mid_frame();
      test_reuse_without_key();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
